// File: rtl/e203_sysmem_icb2axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : e203_sysmem_icb2axi_pkg
//  Purpose : Shared constants for the sysmem ICB-to-AXI bridge: bus widths
//            and the fixed AXI attribute values driven on AR/AW.
//  Revision: 1.0 - initial release
// ============================================================================
package e203_sysmem_icb2axi_pkg;

    // Bus widths
    localparam int C_ADDR_W  = 32;
    localparam int C_ICB_DW  = 32;
    localparam int C_ICB_MW  = C_ICB_DW / 8;
    localparam int C_AXI_DW  = 64;
    localparam int C_AXI_SW  = C_AXI_DW / 8;

    // Fixed single-beat AXI attributes
    localparam logic [3:0] C_AXI_CACHE = 4'h0;
    localparam logic [2:0] C_AXI_PROT  = 3'h0;
    localparam logic [1:0] C_AXI_LOCK  = 2'h0;
    localparam logic [1:0] C_AXI_BURST = 2'b01;
    localparam logic [3:0] C_AXI_LEN   = 4'h0;
    localparam logic [2:0] C_AXI_SIZE  = 3'b010;

    // Outstanding-tracking FIFO entry: {is_read, addr[2]}
    localparam int C_TRK_W   = 2;
    localparam int C_TRK_RD  = 1;
    localparam int C_TRK_A2  = 0;

endpackage
`default_nettype wire

// File: rtl/sirv_gnrl_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : sirv_gnrl_fifo
//  Purpose : Small synchronous FIFO with valid/ready on both sides. Input
//            ready depends only on occupancy (no cut-through, no bypass).
//  Revision: 1.0 - initial release
// ============================================================================
module sirv_gnrl_fifo #(
    parameter int DP = 2,
    parameter int DW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat
);

    localparam int PTR_W = (DP > 1) ? $clog2(DP) : 1;
    localparam int CNT_W = $clog2(DP + 1);

    logic [DW-1:0]    r_mem [0:DP-1];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_cnt;

    logic w_push;
    logic w_pop;

    assign i_rdy  = (r_cnt != CNT_W'(DP));
    assign o_vld  = (r_cnt != '0);
    assign o_dat  = r_mem[r_rptr];
    assign w_push = i_vld & i_rdy;
    assign w_pop  = o_vld & o_rdy;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DP - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage, pointers and occupancy counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DP; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_dat;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/e203_sysmem_icb2axi.sv
`default_nettype none
// ============================================================================
//  Module  : e203_sysmem_icb2axi
//  Purpose : 32-bit ICB master to 64-bit single-beat AXI master bridge.
//            One AXI transaction per ICB command, up to OUTS_DEPTH in
//            flight, responses returned in command order.
//  Options : E203_ICB2AXI_ERR_EN - when defined, icb_rsp_err reflects
//            rresp[1]/bresp[1] of the head transaction; otherwise tied 0.
//  Revision: 1.0 - initial release
// ============================================================================
module e203_sysmem_icb2axi
    import e203_sysmem_icb2axi_pkg::*;
#(
    parameter int OUTS_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                icb_cmd_valid,
    output logic                icb_cmd_ready,
    input  logic [C_ADDR_W-1:0] icb_cmd_addr,
    input  logic                icb_cmd_read,
    input  logic [C_ICB_DW-1:0] icb_cmd_wdata,
    input  logic [C_ICB_MW-1:0] icb_cmd_wmask,

    output logic                icb_rsp_valid,
    input  logic                icb_rsp_ready,
    output logic                icb_rsp_err,
    output logic [C_ICB_DW-1:0] icb_rsp_rdata,

    output logic                axi_arvalid,
    input  logic                axi_arready,
    output logic [C_ADDR_W-1:0] axi_araddr,
    output logic [3:0]          axi_arcache,
    output logic [2:0]          axi_arprot,
    output logic [1:0]          axi_arlock,
    output logic [1:0]          axi_arburst,
    output logic [3:0]          axi_arlen,
    output logic [2:0]          axi_arsize,

    output logic                axi_awvalid,
    input  logic                axi_awready,
    output logic [C_ADDR_W-1:0] axi_awaddr,
    output logic [3:0]          axi_awcache,
    output logic [2:0]          axi_awprot,
    output logic [1:0]          axi_awlock,
    output logic [1:0]          axi_awburst,
    output logic [3:0]          axi_awlen,
    output logic [2:0]          axi_awsize,

    input  logic                axi_rvalid,
    output logic                axi_rready,
    input  logic [C_AXI_DW-1:0] axi_rdata,
    input  logic [1:0]          axi_rresp,
    input  logic                axi_rlast,

    output logic                axi_wvalid,
    input  logic                axi_wready,
    output logic [C_AXI_DW-1:0] axi_wdata,
    output logic [C_AXI_SW-1:0] axi_wstrb,
    output logic                axi_wlast,

    input  logic                axi_bvalid,
    output logic                axi_bready,
    input  logic [1:0]          axi_bresp
);

    logic                r_ar_pend;
    logic                r_aw_pend;
    logic                r_w_pend;
    logic [C_ADDR_W-1:0] r_araddr;
    logic [C_ADDR_W-1:0] r_awaddr;
    logic [C_AXI_DW-1:0] r_wdata;
    logic [C_AXI_SW-1:0] r_wstrb;

    logic                w_cmd_hsk;
    logic                w_fifo_i_rdy;
    logic                w_fifo_o_vld;
    logic                w_fifo_o_rdy;
    logic [C_TRK_W-1:0]  w_fifo_i_dat;
    logic [C_TRK_W-1:0]  w_head;
    logic                w_head_rd;
    logic                w_head_a2;
    logic                w_head_rsp_vld;
    logic                w_unused;

    // A new command waits for a free tracking slot and for every AXI
    // address/data channel of the previous command to have handshaked.
    assign icb_cmd_ready = rst_n & w_fifo_i_rdy & ~r_ar_pend & ~r_aw_pend & ~r_w_pend;
    assign w_cmd_hsk     = icb_cmd_valid & icb_cmd_ready;
    assign w_fifo_i_dat  = {icb_cmd_read, icb_cmd_addr[2]};

    sirv_gnrl_fifo #(
        .DP (OUTS_DEPTH),
        .DW (C_TRK_W)
    ) u_trk_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .i_vld (w_cmd_hsk),
        .i_rdy (w_fifo_i_rdy),
        .i_dat (w_fifo_i_dat),
        .o_vld (w_fifo_o_vld),
        .o_rdy (w_fifo_o_rdy),
        .o_dat (w_head)
    );

    // AR/AW/W request registers: loaded on accept, each cleared on its own ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ar_pend <= 1'b0;
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
            r_araddr  <= '0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            if (w_cmd_hsk && icb_cmd_read) begin
                r_ar_pend <= 1'b1;
                r_araddr  <= icb_cmd_addr;
            end else if (r_ar_pend && axi_arready) begin
                r_ar_pend <= 1'b0;
            end

            if (w_cmd_hsk && !icb_cmd_read) begin
                r_aw_pend <= 1'b1;
                r_w_pend  <= 1'b1;
                r_awaddr  <= icb_cmd_addr;
                r_wdata   <= {icb_cmd_wdata, icb_cmd_wdata};
                r_wstrb   <= icb_cmd_addr[2] ? {icb_cmd_wmask, 4'b0000}
                                             : {4'b0000, icb_cmd_wmask};
            end else begin
                if (r_aw_pend && axi_awready) begin
                    r_aw_pend <= 1'b0;
                end
                if (r_w_pend && axi_wready) begin
                    r_w_pend <= 1'b0;
                end
            end
        end
    end

    assign axi_arvalid = r_ar_pend;
    assign axi_araddr  = r_araddr;
    assign axi_arcache = C_AXI_CACHE;
    assign axi_arprot  = C_AXI_PROT;
    assign axi_arlock  = C_AXI_LOCK;
    assign axi_arburst = C_AXI_BURST;
    assign axi_arlen   = C_AXI_LEN;
    assign axi_arsize  = C_AXI_SIZE;

    assign axi_awvalid = r_aw_pend;
    assign axi_awaddr  = r_awaddr;
    assign axi_awcache = C_AXI_CACHE;
    assign axi_awprot  = C_AXI_PROT;
    assign axi_awlock  = C_AXI_LOCK;
    assign axi_awburst = C_AXI_BURST;
    assign axi_awlen   = C_AXI_LEN;
    assign axi_awsize  = C_AXI_SIZE;

    assign axi_wvalid  = r_w_pend;
    assign axi_wdata   = r_wdata;
    assign axi_wstrb   = r_wstrb;
    assign axi_wlast   = 1'b1;

    // Response path is steered purely by the oldest outstanding command;
    // the other channel's ready stays low so out-of-order replies wait.
    assign w_head_rd      = w_head[C_TRK_RD];
    assign w_head_a2      = w_head[C_TRK_A2];
    assign w_head_rsp_vld = w_head_rd ? axi_rvalid : axi_bvalid;

    assign icb_rsp_valid  = w_fifo_o_vld & w_head_rsp_vld;
    assign w_fifo_o_rdy   = icb_rsp_ready & w_head_rsp_vld;
    assign axi_rready     = w_fifo_o_vld &  w_head_rd & icb_rsp_ready;
    assign axi_bready     = w_fifo_o_vld & ~w_head_rd & icb_rsp_ready;
    assign icb_rsp_rdata  = (w_fifo_o_vld && w_head_rd)
                          ? (w_head_a2 ? axi_rdata[63:32] : axi_rdata[31:0])
                          : '0;

`ifdef E203_ICB2AXI_ERR_EN
    assign icb_rsp_err = w_fifo_o_vld & (w_head_rd ? axi_rresp[1] : axi_bresp[1]);
`else
    assign icb_rsp_err = 1'b0;
`endif

    // rlast is meaningless for len 0; resp codes only matter with error reporting
    assign w_unused = ^{axi_rlast, axi_rresp, axi_bresp};

endmodule
`default_nettype wire

// File: tb/tb_e203_sysmem_icb2axi.sv
`default_nettype none
// ============================================================================
//  Module  : tb_e203_sysmem_icb2axi
//  Purpose : Directed self-checking bench for the sysmem ICB-to-AXI bridge,
//            with an in-order transaction-queue reference model.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_e203_sysmem_icb2axi;

    localparam int OUTS_DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
    logic [31:0] icb_cmd_addr, icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
    logic [31:0] icb_rsp_rdata;
    logic        axi_arvalid, axi_arready, axi_awvalid, axi_awready;
    logic [31:0] axi_araddr, axi_awaddr;
    logic [3:0]  axi_arcache, axi_awcache, axi_arlen, axi_awlen;
    logic [2:0]  axi_arprot, axi_awprot, axi_arsize, axi_awsize;
    logic [1:0]  axi_arlock, axi_awlock, axi_arburst, axi_awburst;
    logic        axi_rvalid, axi_rready, axi_rlast;
    logic [63:0] axi_rdata;
    logic [1:0]  axi_rresp, axi_bresp;
    logic        axi_wvalid, axi_wready, axi_wlast, axi_bvalid, axi_bready;
    logic [63:0] axi_wdata;
    logic [7:0]  axi_wstrb;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    e203_sysmem_icb2axi #(.OUTS_DEPTH(OUTS_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_err(icb_rsp_err), .icb_rsp_rdata(icb_rsp_rdata),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_arcache(axi_arcache), .axi_arprot(axi_arprot), .axi_arlock(axi_arlock),
        .axi_arburst(axi_arburst), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awcache(axi_awcache), .axi_awprot(axi_awprot), .axi_awlock(axi_awlock),
        .axi_awburst(axi_awburst), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Outstanding commands in order, each {is_read, addr[2]}; plus the
    // request each AXI channel is still offering.
    bit [1:0]    m_q[$];
    bit          m_ar, m_aw, m_w;
    logic [31:0] m_araddr, m_awaddr;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;

    task automatic model_step();
        logic        e_ready, e_vld, e_rr, e_br, e_err;
        logic [31:0] e_rdata;
        bit [1:0]    h;
        e_ready = rst_n && (m_q.size() < OUTS_DEPTH) && !m_ar && !m_aw && !m_w;
        e_vld = 1'b0; e_rr = 1'b0; e_br = 1'b0; e_err = 1'b0; e_rdata = '0;
        if (m_q.size() > 0) begin
            h = m_q[0];
            if (h[1]) begin
                e_vld   = axi_rvalid;
                e_rr    = icb_rsp_ready;
                e_rdata = h[0] ? axi_rdata[63:32] : axi_rdata[31:0];
`ifdef E203_ICB2AXI_ERR_EN
                e_err   = axi_rresp[1];
`endif
            end else begin
                e_vld   = axi_bvalid;
                e_br    = icb_rsp_ready;
`ifdef E203_ICB2AXI_ERR_EN
                e_err   = axi_bresp[1];
`endif
            end
        end
        if (chk_en) begin
            chk("cyc_cmd_ready", icb_cmd_ready, e_ready);
            chk("cyc_arvalid",   axi_arvalid,   m_ar);
            chk("cyc_awvalid",   axi_awvalid,   m_aw);
            chk("cyc_wvalid",    axi_wvalid,    m_w);
            chk("cyc_araddr",    axi_araddr,    m_araddr);
            chk("cyc_awaddr",    axi_awaddr,    m_awaddr);
            chk("cyc_wdata",     axi_wdata,     m_wdata);
            chk("cyc_wstrb",     axi_wstrb,     m_wstrb);
            chk("cyc_rsp_valid", icb_rsp_valid, e_vld);
            chk("cyc_rready",    axi_rready,    e_rr);
            chk("cyc_bready",    axi_bready,    e_br);
            chk("cyc_rsp_rdata", icb_rsp_rdata, e_rdata);
            chk("cyc_rsp_err",   icb_rsp_err,   e_err);
        end
        // Advance to the state after the coming rising edge
        if (!rst_n) begin
            m_q.delete();
            m_ar = 0; m_aw = 0; m_w = 0;
            m_araddr = '0; m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
        end else begin
            if (m_ar && axi_arready) m_ar = 0;
            if (m_aw && axi_awready) m_aw = 0;
            if (m_w  && axi_wready)  m_w  = 0;
            if (e_vld && icb_rsp_ready) void'(m_q.pop_front());
            if (icb_cmd_valid && e_ready) begin
                m_q.push_back({icb_cmd_read, icb_cmd_addr[2]});
                if (icb_cmd_read) begin
                    m_ar = 1; m_araddr = icb_cmd_addr;
                end else begin
                    m_aw = 1; m_w = 1; m_awaddr = icb_cmd_addr;
                    m_wdata = {icb_cmd_wdata, icb_cmd_wdata};
                    m_wstrb = icb_cmd_addr[2] ? {icb_cmd_wmask, 4'b0} : {4'b0, icb_cmd_wmask};
                end
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        model_step();
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
        #1;
    endtask

    task automatic set_cmd(input bit rd, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        icb_cmd_valid = 1'b1; icb_cmd_read = rd; icb_cmd_addr = a;
        icb_cmd_wdata = d; icb_cmd_wmask = m;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 0; icb_cmd_valid = 0; icb_cmd_read = 0; icb_cmd_addr = '0;
        icb_cmd_wdata = '0; icb_cmd_wmask = '0; icb_rsp_ready = 1;
        axi_arready = 0; axi_awready = 0; axi_wready = 0; axi_rvalid = 0;
        axi_rdata = '0; axi_rresp = '0; axi_rlast = 1; axi_bvalid = 0; axi_bresp = '0;
        m_ar = 0; m_aw = 0; m_w = 0;
        m_araddr = '0; m_awaddr = '0; m_wdata = '0; m_wstrb = '0;

        repeat (3) step();
        chk_en = 1'b1;
        neg();
        chk("rst_arvalid", axi_arvalid, 0);
        chk("rst_rsp_valid", icb_rsp_valid, 0);
        step(); rst_n = 1;
        neg();
        chk("post_rst_cmd_ready", icb_cmd_ready, 1);
        chk("ar_const", {axi_arcache, axi_arprot, axi_arlock, axi_arburst, axi_arlen, axi_arsize},
            {4'h0, 3'h0, 2'h0, 2'b01, 4'h0, 3'b010});
        chk("aw_const", {axi_awcache, axi_awprot, axi_awlock, axi_awburst, axi_awlen, axi_awsize, axi_wlast},
            {4'h0, 3'h0, 2'h0, 2'b01, 4'h0, 3'b010, 1'b1});

        // Single read, upper word
        step(); set_cmd(1, 32'h8000_0004, 0, 0);
        step(); icb_cmd_valid = 0; axi_arready = 1;
        neg();
        chk("rd1_arvalid", axi_arvalid, 1);
        chk("rd1_araddr", axi_araddr, 32'h8000_0004);
        step(); axi_arready = 0; axi_rvalid = 1; axi_rdata = 64'h1111_2222_3333_4444;
        neg();
        chk("rd1_rsp_valid", icb_rsp_valid, 1);
        chk("rd1_rdata", icb_rsp_rdata, 32'h1111_2222);
        chk("rd1_err", icb_rsp_err, 0);
        step(); axi_rvalid = 0; axi_rdata = '0;

        // Write with delayed awready
        set_cmd(0, 32'h8000_0000, 32'hDEAD_BEEF, 4'b0011);
        step(); icb_cmd_valid = 0; axi_wready = 1;
        neg();
        chk("wr_wstrb", axi_wstrb, 8'h03);
        chk("wr_wdata", axi_wdata, 64'hDEADBEEF_DEADBEEF);
        chk("wr_cmd_ready_lo0", icb_cmd_ready, 0);
        step(); axi_wready = 0;
        neg(); chk("wr_cmd_ready_lo1", icb_cmd_ready, 0);
        step();
        neg(); chk("wr_cmd_ready_lo2", icb_cmd_ready, 0);
        step(); axi_awready = 1;
        neg(); chk("wr_cmd_ready_lo3", icb_cmd_ready, 0);
        step(); axi_awready = 0;
        neg();
        chk("wr_cmd_ready_hi", icb_cmd_ready, 1);
        chk("wr_no_rsp_yet", icb_rsp_valid, 0);
        step(); axi_bvalid = 1;
        neg();
        chk("wr_rsp_valid", icb_rsp_valid, 1);
        chk("wr_bready", axi_bready, 1);
        step(); axi_bvalid = 0;
        neg(); chk("wr_rsp_done", icb_rsp_valid, 0);

        // Read then write outstanding; B arrives before R
        step(); set_cmd(1, 32'h8000_0010, 0, 0);
        step(); icb_cmd_valid = 0; axi_arready = 1;
        step(); axi_arready = 0; set_cmd(0, 32'h8000_000C, 32'h0123_4567, 4'b1100);
        step(); icb_cmd_valid = 0; axi_awready = 1; axi_wready = 1;
        neg(); chk("rw_wstrb", axi_wstrb, 8'hC0);
        step(); axi_awready = 0; axi_wready = 0; axi_bvalid = 1;
        neg();
        chk("rw_bready_held", axi_bready, 0);
        chk("rw_rsp_held", icb_rsp_valid, 0);
        step();
        neg(); chk("rw_bready_held2", axi_bready, 0);
        step(); axi_rvalid = 1; axi_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        neg();
        chk("rw_rd_first", icb_rsp_rdata, 32'hCCCC_DDDD);
        chk("rw_rready", axi_rready, 1);
        step(); axi_rvalid = 0; axi_rdata = '0;
        neg();
        chk("rw_wr_second", axi_bready, 1);
        chk("rw_wr_rdata0", icb_rsp_rdata, 0);
        step(); axi_bvalid = 0;

        // Depth limit: third read stalls until a pop
        set_cmd(1, 32'h0000_0100, 0, 0);
        step(); icb_cmd_valid = 0; axi_arready = 1;
        step(); axi_arready = 0; set_cmd(1, 32'h0000_0104, 0, 0);
        step(); icb_cmd_valid = 0; axi_arready = 1;
        step(); axi_arready = 0; set_cmd(1, 32'h0000_0108, 0, 0);
        neg(); chk("full_stall0", icb_cmd_ready, 0);
        step();
        neg(); chk("full_stall1", icb_cmd_ready, 0);
        step(); axi_rvalid = 1; axi_rdata = 64'h0000_0002_0000_0001;
        neg();
        chk("full_pop_no_bypass", icb_cmd_ready, 0);
        chk("full_rdata_a", icb_rsp_rdata, 32'h1);
        step(); axi_rvalid = 0;
        neg(); chk("full_accept", icb_cmd_ready, 1);
        step(); icb_cmd_valid = 0; axi_arready = 1;
        neg(); chk("full_third_araddr", axi_araddr, 32'h0000_0108);
        step(); axi_arready = 0; axi_rvalid = 1; axi_rdata = 64'h0000_0004_0000_0003;
        neg(); chk("full_rdata_b", icb_rsp_rdata, 32'h4);
        step(); axi_rdata = 64'h0000_0006_0000_0005;
        neg(); chk("full_rdata_c", icb_rsp_rdata, 32'h5);
        step(); axi_rvalid = 0; axi_rdata = '0;

        // Error response on read
        set_cmd(1, 32'h8000_0020, 0, 0);
        step(); icb_cmd_valid = 0; axi_arready = 1;
        step(); axi_arready = 0; axi_rvalid = 1; axi_rresp = 2'b10;
        neg();
`ifdef E203_ICB2AXI_ERR_EN
        chk("err_slverr", icb_rsp_err, 1);
`else
        chk("err_slverr", icb_rsp_err, 0);
`endif
        step(); axi_rvalid = 0; axi_rresp = 2'b00;

        // Reset while a write is pending
        set_cmd(0, 32'h8000_0040, 32'h5A5A_5A5A, 4'hF);
        step(); icb_cmd_valid = 0;
        neg(); chk("rst_mid_awvalid_pre", axi_awvalid, 1);
        step(); rst_n = 0;
        step();
        neg();
        chk("rst_mid_awvalid", axi_awvalid, 0);
        chk("rst_mid_wvalid", axi_wvalid, 0);
        step(); rst_n = 1; axi_bvalid = 1;
        neg();
        chk("rst_mid_cmd_ready", icb_cmd_ready, 1);
        chk("rst_mid_fifo_empty", icb_rsp_valid, 0);
        step(); axi_bvalid = 0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/e203_sysmem_icb2axi.md
# e203_sysmem_icb2axi

Bridge from the subsystem's 32-bit sysmem ICB master port to the 64-bit single-beat AXI master pins at SoC top. Accepts ICB read/write commands, issues one AXI transaction per command, tracks up to OUTS_DEPTH outstanding transactions in order, and returns ICB responses in command order. Sits directly between e203_subsys_top sysmem_icb_* and the SoC axi_* pins.

## Interface
- OUTS_DEPTH, 2, max outstanding transactions; 1..8.
- clk  in  1  sole clock.
- rst_n  in  1  reset, synchronous, active-low.
- icb_cmd_valid / icb_cmd_ready  in / out  1 / 1  ICB command handshake.
- icb_cmd_addr  in  32  byte address.
- icb_cmd_read  in  1  1 = read, 0 = write.
- icb_cmd_wdata / icb_cmd_wmask  in  32 / 4  write data and byte mask.
- icb_rsp_valid / icb_rsp_ready  out / in  1 / 1  ICB response handshake.
- icb_rsp_err / icb_rsp_rdata  out  1 / 32  error flag, read data.
- axi_arvalid / axi_arready / axi_araddr  out / in / out  1 / 1 / 32  read address.
- axi_awvalid / axi_awready / axi_awaddr  out / in / out  1 / 1 / 32  write address.
- axi_{ar,aw}{cache,prot,lock,burst,len,size}  out  4,3,2,2,4,3  constants: cache 0, prot 0, lock 0, burst 2'b01, len 0, size 3'b010.
- axi_rvalid / axi_rready / axi_rdata / axi_rresp / axi_rlast  in / out / in / in / in  1 / 1 / 64 / 2 / 1.
- axi_wvalid / axi_wready / axi_wdata / axi_wstrb / axi_wlast  out / in / out / out / out  1 / 1 / 64 / 8 / 1; wlast constant 1.
- axi_bvalid / axi_bready / axi_bresp  in / out / in  1 / 1 / 2.

## Operation
- icb_cmd_ready = ~fifo_full & ~ar_pend & ~aw_pend & ~w_pend.
- Read accept: register araddr = addr; set ar_pend; push {is_rd=1, addr[2]}.
- Write accept: register awaddr; wdata = {wdata, wdata}; wstrb = addr[2] ? {wmask, 4'b0} : {4'b0, wmask}; set aw_pend and w_pend; push {is_rd=0, addr[2]}.
- axi_arvalid = ar_pend; clear on arready. Likewise aw_pend/awready and w_pend/wready, independently; AW and W may complete in either order.
- Response path is combinational from the FIFO head:
  - head read: rsp_valid = rvalid; rready = rsp_ready; rdata = head.addr2 ? axi_rdata[63:32] : axi_rdata[31:0].
  - head write: rsp_valid = bvalid; bready = rsp_ready; rdata = 0.
  - The channel not matching the head holds its ready at 0. FIFO empty: both readies 0, rsp_valid 0.
- Pop on rsp_valid & rsp_ready. Push and pop in the same cycle are legal; occupancy is unchanged.
- Full: cmd_ready = 0 even if a pop occurs the same cycle; no bypass.
- rlast is ignored, since len = 0.

## Timing
- Reset values: all valid/ready outputs 0; address/data/strb registers 0; FIFO empty; icb_rsp_err 0; icb_cmd_ready 1 the cycle after reset releases.
- ICB command handshake in cycle N gives ar/aw/wvalid = 1 in N+1.
- Next command is accepted no earlier than the cycle after all of the previous command's AXI address/data handshakes complete.
- Response latency: 0 cycles from rvalid/bvalid to icb_rsp_valid.
- Reset asserted mid-transaction: all pending state is dropped at the next clk edge. The AXI slave must be reset concurrently.

## Configuration
- E203_ICB2AXI_ERR_EN:
  - Defined: icb_rsp_err = head-selected resp[1] (SLVERR or DECERR gives 1).
  - Undefined: icb_rsp_err tied 0; rresp/bresp unused.

## Structure
- Constants for AXI attribute values and address/data widths go in the shared defines file; no typedefs.
- FIFO is a sirv_gnrl_fifo sub-module instance: width 2, depth OUTS_DEPTH, no cut-through. Everything else lives in one module.

## Test plan
- Single read at 0x8000_0004; slave returns rdata 0x1111_2222_3333_4444, rresp 0 -> arvalid in N+1 with araddr 0x8000_0004, size 2, len 0; icb_rsp_rdata 0x1111_2222, err 0.
- Write at 0x8000_0000, wdata 0xDEAD_BEEF, wmask 4'b0011; awready delayed 3 cycles, wready immediate -> wstrb 8'h03, wdata 0xDEADBEEF_DEADBEEF; one response after bvalid; cmd_ready low until awready.
- Read then write outstanding; slave asserts bvalid before rvalid -> bready held 0 until the read response pops; responses arrive in order read, write.
- OUTS_DEPTH = 2 with three back-to-back reads and no rvalid -> third command stalls (cmd_ready 0); first response pop with simultaneous pending command -> accepted the following cycle.
- With E203_ICB2AXI_ERR_EN, rresp 2'b10 -> icb_rsp_err 1. Without the macro, same stimulus -> err 0.
- rst_n low during a pending aw_pend -> next cycle all valids 0, FIFO empty, cmd_ready 1 after release.
